// File: rtl/demux_frame_ctrl.sv
// Per-frame sequencer for the forward/trash frame demux: holds one decision per frame and re-times data by one stage.
// Optional statistics counters are built only when DEMUX_FRAME_CTRL_STATS_EN is defined.
module demux_frame_ctrl #(
  parameter int W       = 9,
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din_valid,
  input  logic [W-1:0]  din,
  output logic          din_ready,
  input  logic          dec_valid,
  input  logic          dec_fwd,
  output logic          dec_ready,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  output logic          sel,
  output logic [CW-1:0] fwd_cnt,
  output logic [CW-1:0] drop_cnt,
  output logic [CW-1:0] timeout_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

  state_t         state_q;
  logic [15:0]    stall_q;
  logic [W-1:0]   dout_q;
  logic           dout_valid_q;

  logic           din_ready_d;
  logic           dec_ready_d;
  logic           fwd_d;
  logic           accept;
  logic           eof;
  logic           tmo_hit;

  assign eof     = din[W-1];
  assign tmo_hit = (stall_q == STALL_LAST);

  // A decision always wins over the timeout when both are available in IDLE.
  always_comb begin
    din_ready_d = 1'b0;
    dec_ready_d = 1'b0;
    fwd_d       = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          din_ready_d = din_valid && (dec_valid || tmo_hit);
          dec_ready_d = din_valid && dec_valid;
          fwd_d       = dec_valid && dec_fwd;
        end
        FWD: begin
          din_ready_d = 1'b1;
          fwd_d       = 1'b1;
        end
        DROP:    din_ready_d = 1'b1;
        default: din_ready_d = 1'b0;
      endcase
    end
  end

  assign accept     = din_valid && din_ready_d;
  assign din_ready  = din_ready_d;
  assign dec_ready  = dec_ready_d;
  assign sel        = accept && fwd_d;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      stall_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= accept;
      dout_q       <= accept ? din : '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            stall_q <= '0;
            if (!eof) state_q <= fwd_d ? FWD : DROP;
          end else if (din_valid) begin
            stall_q <= stall_q + 16'd1;
          end else begin
            stall_q <= '0;
          end
        end
        FWD, DROP: begin
          if (accept && eof) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DEMUX_FRAME_CTRL_STATS_EN
  logic           tmo_q;
  logic           end_tmo;
  logic [CW-1:0]  fwd_q;
  logic [CW-1:0]  drop_q;
  logic [CW-1:0]  tmo_cnt_q;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  // A timed-out frame is only counted at its EOF, so remember how it was opened.
  assign end_tmo = (state_q == IDLE) ? !dec_valid : tmo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q     <= 1'b0;
      fwd_q     <= '0;
      drop_q    <= '0;
      tmo_cnt_q <= '0;
    end else begin
      if (accept && state_q == IDLE) tmo_q <= !dec_valid;
      if (accept && eof) begin
        if (fwd_d) begin
          fwd_q <= sat_inc(fwd_q);
        end else begin
          drop_q <= sat_inc(drop_q);
          if (end_tmo) tmo_cnt_q <= sat_inc(tmo_cnt_q);
        end
      end
    end
  end

  assign fwd_cnt     = fwd_q;
  assign drop_cnt    = drop_q;
  assign timeout_cnt = tmo_cnt_q;
`else
  assign fwd_cnt     = '0;
  assign drop_cnt    = '0;
  assign timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_frame_ctrl.sv
// Scoreboard bench for demux_frame_ctrl: directed frames then randomized traffic against a frame-level model.
module tb_demux_frame_ctrl;
  localparam int W   = 9;
  localparam int TMO = 8;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_valid = 1'b0;
  logic [W-1:0]  din = '0;
  logic          din_ready;
  logic          dec_valid = 1'b0;
  logic          dec_fwd = 1'b0;
  logic          dec_ready;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          sel;
  logic [CW-1:0] fwd_cnt, drop_cnt, timeout_cnt;

  demux_frame_ctrl #(.W(W), .TIMEOUT(TMO), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .dec_valid(dec_valid), .dec_fwd(dec_fwd), .dec_ready(dec_ready),
    .dout(dout), .dout_valid(dout_valid), .sel(sel),
    .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  // Frame-level reference: is a frame open, how it is routed, how long the head word has waited.
  bit m_open, m_open_fwd, m_open_tmo;
  int m_wait;
  int m_fwd, m_drop, m_tmo;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic cyc(input bit r, input bit dv, input logic [W-1:0] d, input bit cv, input bit cf);
    bit e_dinr, e_decr, acc, fwd, tmo, eof;
    @(posedge clk);
    #1;
    rst = r; din_valid = dv; din = d; dec_valid = cv; dec_fwd = cf;
    #1;
`ifdef DEMUX_FRAME_CTRL_STATS_EN
    chk("fwd_cnt", int'(fwd_cnt), m_fwd);
    chk("drop_cnt", int'(drop_cnt), m_drop);
    chk("timeout_cnt", int'(timeout_cnt), m_tmo);
`else
    chk("fwd_cnt_off", int'(fwd_cnt), 0);
    chk("drop_cnt_off", int'(drop_cnt), 0);
    chk("timeout_cnt_off", int'(timeout_cnt), 0);
`endif
    if (r) begin
      chk("rst_din_ready", int'(din_ready), 0);
      chk("rst_dec_ready", int'(dec_ready), 0);
      chk("rst_sel", int'(sel), 0);
      m_open = 0; m_wait = 0; m_fwd = 0; m_drop = 0; m_tmo = 0;
      return;
    end
    eof = d[W-1];
    if (!m_open) begin
      e_decr = dv && cv;
      e_dinr = dv && (cv || m_wait == TMO - 1);
      fwd = cv && cf;
      tmo = !cv;
    end else begin
      e_decr = 0;
      e_dinr = 1;
      fwd = m_open_fwd;
      tmo = m_open_tmo;
    end
    acc = dv && e_dinr;
    chk("din_ready", int'(din_ready), int'(e_dinr));
    chk("dec_ready", int'(dec_ready), int'(e_decr));
    chk("sel", int'(sel), int'(acc && fwd));
    if (acc) begin
      exp_q.push_back(d);
      m_wait = 0;
      if (eof) begin
        m_open = 0;
        if (fwd) m_fwd = sat(m_fwd);
        else begin
          m_drop = sat(m_drop);
          if (tmo) m_tmo = sat(m_tmo);
        end
      end else begin
        m_open = 1; m_open_fwd = fwd; m_open_tmo = tmo;
      end
    end else if (!m_open && dv) begin
      m_wait++;
    end else begin
      m_wait = 0;
    end
  endtask

  // Monitor: every word presented on dout must be the next one the model accepted.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("dout_unexpected", int'(dout), -1);
      end else begin
        chk("dout", int'(dout), int'(exp_q.pop_front()));
      end
    end else if (dout_valid === 1'b0) begin
      chk("dout_idle_zero", int'(dout), 0);
    end
  end

  initial begin
    int p_dec;
    logic [W-1:0] w;
    cyc(1, 0, '0, 0, 0);
    cyc(1, 1, 9'h011, 1, 1);
    cyc(0, 0, '0, 0, 0);
    // basic forward
    cyc(0, 1, 9'h011, 1, 1);
    cyc(0, 1, 9'h022, 0, 0);
    cyc(0, 1, 9'h133, 0, 0);
    cyc(0, 0, '0, 0, 0);
    // basic drop
    cyc(0, 1, 9'h0A1, 1, 0);
    cyc(0, 1, 9'h0A2, 0, 0);
    cyc(0, 0, 9'h0A3, 1, 1);
    cyc(0, 1, 9'h0A3, 0, 0);
    cyc(0, 1, 9'h1FF, 0, 0);
    cyc(0, 0, '0, 0, 0);
    // decision stall shorter than the timeout
    for (int i = 0; i < 5; i++) cyc(0, 1, 9'h041, 0, 0);
    cyc(0, 1, 9'h041, 1, 1);
    cyc(0, 1, 9'h142, 0, 0);
    cyc(0, 0, '0, 0, 0);
    // timeout: no decision, 2-word frame, then a decision with no word
    for (int i = 0; i < TMO; i++) cyc(0, 1, 9'h0B1, 0, 0);
    cyc(0, 1, 9'h1B2, 1, 1);
    cyc(0, 0, '0, 1, 1);
    cyc(0, 0, '0, 0, 0);
    // back-to-back single-word frames
    cyc(0, 1, 9'h1AA, 1, 1);
    cyc(0, 1, 9'h1BB, 1, 0);
    cyc(0, 0, '0, 0, 0);
    // reset mid-frame
    cyc(0, 1, 9'h051, 1, 1);
    cyc(0, 1, 9'h052, 0, 0);
    cyc(1, 1, 9'h053, 0, 0);
    cyc(0, 1, 9'h053, 0, 0);
    cyc(0, 1, 9'h154, 1, 1);
    cyc(0, 0, '0, 0, 0);
    // randomized traffic, alternating decision-rich and decision-starved phases
    for (int k = 0; k < 3000; k++) begin
      p_dec = ((k / 250) % 2 == 1) ? 1 : 6;
      w = W'($urandom);
      w[W-1] = ($urandom_range(0, 3) == 0);
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), w,
          ($urandom_range(0, 7) < p_dec), $urandom_range(0, 1));
    end
    cyc(0, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
